// File: rtl/fp_multiplier_iter_pkg.sv
// fp_mul_pkg: shared types and elaboration helpers for the iterative FP multiplier.
//   bias(ew)            exponent bias 2**(ew-1)-1
//   iter_count(mw, rb)  number of shift-add iterations (mw+1)/rb
//   canonical_nan(ew,mw) quiet NaN {0, all-ones exp, 1, 0..} in the low ew+mw+1 bits
//   classify(...)       operand class from exponent/fraction flags
package fp_mul_pkg;

  typedef enum logic [1:0] {
    FPC_ZERO = 2'd0,
    FPC_NORM = 2'd1,
    FPC_INF  = 2'd2,
    FPC_NAN  = 2'd3
  } fp_class_t;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int iter_count(input int mw, input int rb);
    return (mw + 1) / rb;
  endfunction

  function automatic logic [63:0] canonical_nan(input int ew, input int mw);
    logic [63:0] ones_exp;
    ones_exp = (64'd1 << ew) - 64'd1;
    return (ones_exp << mw) | (64'd1 << (mw - 1));
  endfunction

  // Exponent zero is treated as zero regardless of fraction (denormals are zero).
  function automatic fp_class_t classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero);
    fp_class_t c;
    if (exp_zero) begin
      c = FPC_ZERO;
    end else if (!exp_ones) begin
      c = FPC_NORM;
    end else if (frac_zero) begin
      c = FPC_INF;
    end else begin
      c = FPC_NAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_multiplier_iter_round_pack.sv
// fp_mul_round_pack: combinational normalise / round / exponent range check / pack.
// Optional macro FPMUL_IEEE_SPECIALS_EN selects IEEE special-value handling;
// without it the legacy saturation rules apply.
// Ports:
//   prod_top_i  MW+3    top bits of the product register P[top:top-1-M]
//   sign_i      1       result sign
//   exp_sum_i   EW+1    raw exponent sum xe+ye
//   x_cls_i     class   operand A class
//   y_cls_i     class   operand B class
//   z_o         EW+MW+1 packed result
module fp_mul_round_pack
  import fp_mul_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [MW+2:0]  prod_top_i,
  input  logic           sign_i,
  input  logic [EW:0]    exp_sum_i,
  input  fp_class_t      x_cls_i,
  input  fp_class_t      y_cls_i,
  output logic [EW+MW:0] z_o
);

  localparam int M    = MW + 1;
  localparam int BIAS = bias(EW);
`ifdef FPMUL_IEEE_SPECIALS_EN
  localparam logic [63:0] CNAN_W = canonical_nan(EW, MW);
`endif

  logic          top_s;
  logic [MW:0]   mant_src_s;   // mantissa bits plus guard bit, hidden 1 dropped
  logic [MW-1:0] mant_s;
  logic [EW+1:0] e1_s;         // two's complement, EW+2 bits
  logic          neg_s;

  // Normalise, round half-up at the guard bit, and compute the biased exponent.
  always_comb begin
    top_s      = prod_top_i[M+1];
    mant_src_s = top_s ? prod_top_i[MW+1:1] : prod_top_i[MW:0];
    // Adding 1 at the guard bit carries into the mantissa only when guard=1;
    // a carry out of the mantissa is dropped, not renormalised.
    mant_s     = mant_src_s[MW:1] + MW'(mant_src_s[0]);
    e1_s       = (EW+2)'(exp_sum_i) - (EW+2)'(BIAS) + (EW+2)'(top_s);
    neg_s      = e1_s[EW+1];
  end

  // Special-case selection and packing.
  always_comb begin
    z_o = '0;
`ifdef FPMUL_IEEE_SPECIALS_EN
    if ((x_cls_i == FPC_NAN) || (y_cls_i == FPC_NAN) ||
        ((x_cls_i == FPC_ZERO) && (y_cls_i == FPC_INF)) ||
        ((x_cls_i == FPC_INF) && (y_cls_i == FPC_ZERO))) begin
      z_o = CNAN_W[EW+MW:0];
    end else if ((x_cls_i == FPC_INF) || (y_cls_i == FPC_INF)) begin
      z_o = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
    end else if ((x_cls_i == FPC_ZERO) || (y_cls_i == FPC_ZERO)) begin
      z_o = {sign_i, {(EW+MW){1'b0}}};
    end else if (!neg_s && (e1_s[EW] || (&e1_s[EW-1:0]))) begin
      z_o = {sign_i, {EW{1'b1}}, {MW{1'b0}}};
    end else if (neg_s || (e1_s == '0)) begin
      z_o = {sign_i, {(EW+MW){1'b0}}};
    end else begin
      z_o = {sign_i, e1_s[EW-1:0], mant_s};
    end
`else
    if ((x_cls_i == FPC_ZERO) || (y_cls_i == FPC_ZERO)) begin
      z_o = '0;
    end else if (neg_s) begin
      z_o = '0;
    end else if (e1_s[EW]) begin
      // e1 >= 2**EW saturates the exponent but keeps the mantissa.
      z_o = {sign_i, {EW{1'b1}}, mant_s};
    end else begin
      z_o = {sign_i, e1_s[EW-1:0], mant_s};
    end
`endif
  end

endmodule

// File: rtl/fp_multiplier_iter.sv
// fp_multiplier_iter: iterative shift-add floating-point multiplier with run/stall
// handshake. RB multiplier bits are retired per cycle; the result appears after a
// fixed N+1 stall cycles, N = (MW+1)/RB. Optional macro FPMUL_IEEE_SPECIALS_EN
// enables IEEE Inf/NaN/signed-zero handling in fp_mul_round_pack.
// Ports:
//   clk    in   1        rising-edge clock
//   rst    in   1        asynchronous active-high reset
//   run    in   1        operation request, held until stall drops
//   x, y   in   EW+MW+1  operands {sign, exp, frac}
//   stall  out  1        run & ~done
//   z      out  EW+MW+1  product, valid when run=1 and stall=0
module fp_multiplier_iter
  import fp_mul_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int RB = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [EW+MW:0] x,
  input  logic [EW+MW:0] y,
  output logic           stall,
  output logic [EW+MW:0] z
);

  localparam int M  = MW + 1;
  localparam int N  = iter_count(MW, RB);
  localparam int SW = $clog2(N + 2);
  localparam logic [SW-1:0] S_DONE = SW'(N + 1);

  generate
    if ((M % RB) != 0) begin : g_rb_check
      $error("fp_multiplier_iter: MW+1 must be a multiple of RB");
    end
  endgenerate

  logic [SW-1:0]     s_q, s_d;
  logic [2*M-1:0]    p_q, p_d;
  logic [M-1:0]      x_sig, y_sig;
  logic [M+RB-1:0]   pp_s, sum_s;
  logic [2*M+RB-1:0] wide_s;
  logic [2*M-1:0]    iter_s;
  logic              done_s;
  logic [EW:0]       e0_s;
  fp_class_t         x_cls, y_cls;

  assign x_sig = {1'b1, x[MW-1:0]};
  assign y_sig = {1'b1, y[MW-1:0]};
  assign x_cls = classify(x[EW+MW-1:MW] == '0, &x[EW+MW-1:MW], x[MW-1:0] == '0);
  assign y_cls = classify(y[EW+MW-1:MW] == '0, &y[EW+MW-1:MW], y[MW-1:0] == '0);
  assign e0_s  = {1'b0, x[EW+MW-1:MW]} + {1'b0, y[EW+MW-1:MW]};

  // One shift-add step: add the low RB multiplier bits times 1.frac(y) to the
  // high half, then shift the whole register right by RB.
  always_comb begin
    pp_s   = (M+RB)'(p_q[RB-1:0]) * (M+RB)'(y_sig);
    sum_s  = (M+RB)'(p_q[2*M-1:M]) + pp_s;
    wide_s = {sum_s, p_q[M-1:0]};
    iter_s = (2*M)'(wide_s >> RB);
  end

  // Step counter and product register next state.
  always_comb begin
    s_d = s_q;
    p_d = p_q;
    if (!run || (s_q == S_DONE)) begin
      s_d = '0;
    end else begin
      s_d = s_q + SW'(1);
    end
    if (!run || (s_q == '0)) begin
      p_d = {{M{1'b0}}, x_sig};
    end else if (s_q != S_DONE) begin
      p_d = iter_s;
    end else begin
      p_d = p_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign done_s = (s_q == S_DONE);
  assign stall  = run & ~done_s;

  fp_mul_round_pack #(
    .EW(EW),
    .MW(MW)
  ) u_round_pack (
    .prod_top_i (p_q[2*M-1:M-2]),
    .sign_i     (x[EW+MW] ^ y[EW+MW]),
    .exp_sum_i  (e0_s),
    .x_cls_i    (x_cls),
    .y_cls_i    (y_cls),
    .z_o        (z)
  );

endmodule
